// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the memory/IO bus arbiter.
//   state_t : arbiter FSM states (idle, memory access in progress, completion pulse)
//   owner_t : which requester currently holds (or last held) the memory port
package mio_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter
//   Shares one fixed-latency memory/IO port between the CPU controller and a
//   secondary (DMA/VGA) requester. Round-robin on ties, one access at a time,
//   one-cycle completion pulse per access.
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_rdata, MIO_ready
//   dma_req/dma_we/dma_addr/dma_wdata -> dma_rdata, dma_ack
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata : memory port
//   grant_cpu                  : high while the CPU owns the port
module mio_bus_arbiter
    import mio_defs::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          MIO_ready,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_cpu
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $fatal(1, "mio_bus_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_state_next;
    owner_t        r_owner;
    owner_t        r_last_grant;
    owner_t        w_grant_owner;
    logic          w_grant;
    logic          w_access_done;
    logic          w_cpu_req;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic          r_first;
    logic          r_mem_en;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;
    logic          r_mio_ready;
    logic          r_dma_ack;
    logic          r_grant_cpu;

    assign w_cpu_req = cpu_rd | cpu_wr;

    // Next-state and arbitration decision
    always_comb begin
        w_state_next  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_CPU;
        w_access_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cpu_req || dma_req) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ACCESS;
                    if (w_cpu_req && dma_req)
                        // Tie: hand the port to whoever did not have it last time
                        w_grant_owner = (r_last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
                    else if (w_cpu_req)
                        w_grant_owner = OWN_CPU;
                    else
                        w_grant_owner = OWN_DMA;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_access_done = 1'b1;
                    w_state_next  = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DMA;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_first      <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_mio_ready  <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_grant_cpu  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner      <= w_grant_owner;
                r_last_grant <= w_grant_owner;
                r_cnt        <= CNT_INIT;
                r_first      <= 1'b1;
                if (w_grant_owner == OWN_CPU) begin
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                    r_we        <= cpu_wr;   // rd+wr together counts as a write
                end else begin
                    r_mem_addr  <= dma_addr;
                    r_mem_wdata <= dma_wdata;
                    r_we        <= dma_we;
                end
            end else if (r_state == ST_ACCESS) begin
                r_first <= 1'b0;
                if (r_cnt != 4'd0)
                    r_cnt <= r_cnt - 4'd1;
            end

            if (w_access_done && !r_we) begin
                if (r_owner == OWN_CPU)
                    r_cpu_rdata <= mem_rdata;
                else
                    r_dma_rdata <= mem_rdata;
            end

            // Registered outputs track the state being entered
            r_mem_en    <= (w_state_next == ST_ACCESS);
            r_mio_ready <= w_access_done && (r_owner == OWN_CPU);
            r_dma_ack   <= w_access_done && (r_owner == OWN_DMA);
            if (w_grant)
                r_grant_cpu <= (w_grant_owner == OWN_CPU);
            else if (w_state_next == ST_IDLE)
                r_grant_cpu <= 1'b0;
        end
    end

    // Write strobe only on the first access cycle so the memory sees one write
    assign mem_we    = (r_state == ST_ACCESS) && r_first && r_we;
    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign MIO_ready = r_mio_ready;
    assign dma_ack   = r_dma_ack;
    assign grant_cpu = r_grant_cpu;

endmodule
